// File: rtl/univ_shift_pkg.sv
// Shared types for the universal shift register: operation codes, burst
// control states and the mode-class helper used by the burst launcher.
package univ_shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_ASR  = 3'd6,
        MODE_CLR  = 3'd7
    } mode_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_e;

    // Only modes that move bits can be repeated as a burst.
    function automatic logic is_shift(mode_e m);
        return (m >= MODE_SHL) && (m <= MODE_ASR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One-step next-value function of the register, shared by the single-op
// path and the burst path so both apply identical bit movement.
module shift_step
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] r,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] data,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] r_next
);

    always_comb begin
        r_next = r;
        case (mode)
            MODE_HOLD: r_next = r;
            MODE_LOAD: r_next = data;
            MODE_SHL:  r_next = {r[WIDTH-2:0], sin_r};
            MODE_SHR:  r_next = {sin_l, r[WIDTH-1:1]};
            MODE_ROL:  r_next = {r[WIDTH-2:0], r[WIDTH-1]};
            MODE_ROR:  r_next = {r[0], r[WIDTH-1:1]};
            MODE_ASR:  r_next = {r[WIDTH-1], r[WIDTH-1:1]};
            MODE_CLR:  r_next = '0;
            default:   r_next = r;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register: per-cycle hold/load/shift/rotate/clear plus an
// autonomous multi-shift burst with busy/done status.
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CNT_W-1:0] shamt,
    output logic [WIDTH-1:0] r,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    // Burst handshake: start is taken only when busy is low and ena is high
    // (it is dropped, not queued, while busy). busy rises the edge after
    // start and falls with the last shift; done pulses for exactly the one
    // cycle after that edge and is the earliest cycle a new start is taken.

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    mode_e            mode_in, step_mode;
    logic [WIDTH-1:0] r_q, r_d, r_step;
    logic [CNT_W-1:0] count_q, count_d, shamt_clamped;
    logic             done_q, done_d;

    assign mode_in       = mode_e'(mode);
    assign shamt_clamped = (shamt > MAX_CNT) ? MAX_CNT : shamt;
    assign step_mode     = (state_q == S_BURST) ? mode_q : mode_in;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .mode   (step_mode),
        .data   (data),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .r_next (r_step)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        r_d     = r_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    if (start && is_shift(mode_in)) begin
                        mode_d = mode_in;
                        // A zero-length burst completes immediately.
                        if (shamt_clamped == '0) begin
                            done_d = 1'b1;
                        end else begin
                            count_d = shamt_clamped;
                            state_d = S_BURST;
                        end
                    end else begin
                        r_d = r_step;
                    end
                end
                S_BURST: begin
                    r_d     = r_step;
                    count_d = count_q - ONE;
                    if (count_q == ONE) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_HOLD;
            r_q     <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            r_q     <= r_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign r      = r_q;
    assign sout_l = r_q[WIDTH-1];
    assign sout_r = r_q[0];
    assign busy   = (state_q == S_BURST);
    assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: table-driven single ops, hand-written burst
// corner cases, then randomized traffic against a behavioural model.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                           ROL  = 3'd4, ROR  = 3'd5, ASR = 3'd6, CLR = 3'd7;

    logic          clk = 1'b0;
    logic          rst, ena, sin_l, sin_r, start;
    logic [2:0]    mode;
    logic [W-1:0]  data;
    logic [CW-1:0] shamt;
    logic [W-1:0]  r;
    logic          sout_l, sout_r, busy, done;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [W-1:0] m_r;
    int           m_left;
    logic         m_busy, m_done;
    logic [2:0]   m_mode;
    logic [W-1:0] exp_q[$];

    univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .mode   (mode),
        .data   (data),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .start  (start),
        .shamt  (shamt),
        .r      (r),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [2:0] md, input logic [W-1:0] cur,
                                            input logic [W-1:0] d, input logic sl, input logic sr);
        logic signed [W-1:0] s;
        s = cur;
        case (md)
            LOAD:    return d;
            SHL:     return (cur << 1) | W'(sr);
            SHR:     return (cur >> 1) | (W'(sl) << (W - 1));
            ROL:     return (cur << 1) | (cur >> (W - 1));
            ROR:     return (cur >> 1) | (cur << (W - 1));
            ASR:     return s >>> 1;
            CLR:     return '0;
            default: return cur;
        endcase
    endfunction

    // Applies the rules for one rising edge to the model, using current inputs.
    task automatic model_edge();
        int req;
        if (rst) begin
            m_r = '0; m_left = 0; m_busy = 1'b0; m_done = 1'b0; m_mode = HOLD;
        end else begin
            m_done = 1'b0;
            if (ena) begin
                if (m_busy) begin
                    m_r = ref_op(m_mode, m_r, data, sin_l, sin_r);
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end else if (start && mode >= SHL && mode <= ASR) begin
                    req = int'(shamt);
                    m_left = (req > W) ? W : req;
                    m_mode = mode;
                    if (m_left == 0) m_done = 1'b1;
                    else m_busy = 1'b1;
                end else begin
                    m_r = ref_op(mode, m_r, data, sin_l, sin_r);
                end
            end
        end
    endtask

    task automatic tick(input string tag);
        logic [W-1:0] e;
        @(posedge clk);
        model_edge();
        exp_q.push_back(m_r);
        #1;
        e = exp_q.pop_front();
        check({tag, ".r"}, 32'(r), 32'(e));
        check({tag, ".busy"}, 32'(busy), 32'(m_busy));
        check({tag, ".done"}, 32'(done), 32'(m_done));
        check({tag, ".sout_l"}, 32'(sout_l), 32'(e[W-1]));
        check({tag, ".sout_r"}, 32'(sout_r), 32'(e[0]));
    endtask

    task automatic drive(input logic rs, input logic en, input logic [2:0] md, input logic [W-1:0] d,
                         input logic sl, input logic sr, input logic st, input logic [CW-1:0] sa);
        rst = rs; ena = en; mode = md; data = d; sin_l = sl; sin_r = sr; start = st; shamt = sa;
    endtask

    task automatic load(input logic [W-1:0] v);
        drive(0, 1, LOAD, v, 0, 0, 0, '0);
        tick("load");
    endtask

    typedef struct {
        string        name;
        logic [2:0]   md;
        logic         sl;
        logic         sr;
        logic [W-1:0] init;
        logic [W-1:0] exp_r;
    } vec_t;

    vec_t vecs[8];

    initial begin
        m_r = '0; m_left = 0; m_busy = 1'b0; m_done = 1'b0; m_mode = HOLD;
        vecs[0] = '{"shl", SHL, 1'b0, 1'b1, 8'h96, 8'h2D};
        vecs[1] = '{"shr", SHR, 1'b1, 1'b0, 8'h96, 8'hCB};
        vecs[2] = '{"rol", ROL, 1'b0, 1'b0, 8'h96, 8'h2D};
        vecs[3] = '{"ror", ROR, 1'b1, 1'b1, 8'h96, 8'h4B};
        vecs[4] = '{"asr", ASR, 1'b0, 1'b0, 8'h96, 8'hCB};
        vecs[5] = '{"clr", CLR, 1'b1, 1'b1, 8'h96, 8'h00};
        vecs[6] = '{"hold", HOLD, 1'b1, 1'b1, 8'h5A, 8'h5A};
        vecs[7] = '{"asr_pos", ASR, 1'b1, 1'b1, 8'h6A, 8'h35};

        // Reset
        drive(1, 0, HOLD, '0, 0, 0, 0, '0);
        tick("rst");
        tick("rst");
        check("rst.r", 32'(r), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.done", 32'(done), 0);
        check("rst.souts", 32'({sout_l, sout_r}), 0);

        // Load, then ena low freezes
        drive(0, 1, LOAD, 8'b0101_0011, 0, 0, 0, '0);
        tick("ld53");
        check("ld53.r", 32'(r), 32'h53);
        drive(0, 0, LOAD, 8'hFF, 0, 0, 0, '0);
        tick("freeze");
        check("freeze.r", 32'(r), 32'h53);

        // Single-op table
        for (int i = 0; i < 8; i++) begin
            load(vecs[i].init);
            drive(0, 1, vecs[i].md, 8'hE7, vecs[i].sl, vecs[i].sr, 0, '0);
            tick(vecs[i].name);
            check({"vec.", vecs[i].name}, 32'(r), 32'(vecs[i].exp_r));
        end

        // Start with a non-shift mode is a plain single op with no done
        load(8'h11);
        drive(0, 1, LOAD, 8'hC3, 0, 0, 1, CW'(3));
        tick("start_load");
        check("start_load.r", 32'(r), 32'hC3);
        check("start_load.busy", 32'(busy), 0);
        check("start_load.done", 32'(done), 0);

        // Burst ROL x3 from 8'h81, with start re-asserted while busy
        load(8'h81);
        drive(0, 1, ROL, '0, 0, 0, 1, CW'(3));
        tick("brol.t");
        check("brol.t.r", 32'(r), 32'h81);
        check("brol.t.busy", 32'(busy), 1);
        drive(0, 1, CLR, 8'hAA, 0, 0, 1, CW'(1));
        tick("brol.1");
        check("brol.1.r", 32'(r), 32'h03);
        drive(0, 1, HOLD, '0, 0, 0, 0, '0);
        tick("brol.2");
        check("brol.2.r", 32'(r), 32'h06);
        check("brol.2.busy", 32'(busy), 1);
        tick("brol.3");
        check("brol.3.r", 32'(r), 32'h0C);
        check("brol.3.busy", 32'(busy), 0);
        check("brol.3.done", 32'(done), 1);
        tick("brol.4");
        check("brol.4.done", 32'(done), 0);

        // Clamp: shamt 12 on an 8-bit register gives 8 shifts
        load(8'hFF);
        drive(0, 1, SHL, '0, 0, 0, 1, CW'(12));
        tick("clamp.t");
        drive(0, 1, HOLD, '0, 0, 0, 0, '0);
        for (int i = 1; i <= 7; i++) begin
            tick("clamp.s");
            check("clamp.busy", 32'(busy), 1);
        end
        tick("clamp.8");
        check("clamp.r", 32'(r), 32'h00);
        check("clamp.done", 32'(done), 1);

        // Zero-length burst
        load(8'hA5);
        drive(0, 1, SHL, '0, 0, 1, 1, '0);
        tick("zero.t");
        check("zero.busy", 32'(busy), 0);
        check("zero.done", 32'(done), 1);
        check("zero.r", 32'(r), 32'hA5);
        drive(0, 1, HOLD, '0, 0, 0, 0, '0);
        tick("zero.n");
        check("zero.n.done", 32'(done), 0);

        // Stall: SHR x4 on 8'hF0, ena low for two mid-burst cycles
        load(8'hF0);
        drive(0, 1, SHR, '0, 0, 0, 1, CW'(4));
        tick("stall.t");
        drive(0, 1, HOLD, '0, 0, 0, 0, '0);
        tick("stall.1");
        check("stall.1.r", 32'(r), 32'h78);
        drive(0, 0, HOLD, '0, 0, 0, 0, '0);
        tick("stall.off");
        tick("stall.off");
        check("stall.off.r", 32'(r), 32'h78);
        check("stall.off.busy", 32'(busy), 1);
        drive(0, 1, HOLD, '0, 0, 0, 0, '0);
        tick("stall.2");
        tick("stall.3");
        check("stall.3.done", 32'(done), 0);
        tick("stall.4");
        check("stall.r", 32'(r), 32'h0F);
        check("stall.done", 32'(done), 1);

        // Reset mid-burst aborts without done, next burst is normal
        load(8'h3C);
        drive(0, 1, ROL, '0, 0, 0, 1, CW'(5));
        tick("abort.t");
        drive(0, 1, HOLD, '0, 0, 0, 0, '0);
        tick("abort.1");
        drive(1, 1, HOLD, '0, 0, 0, 0, '0);
        tick("abort.rst");
        check("abort.r", 32'(r), 0);
        check("abort.busy", 32'(busy), 0);
        drive(0, 1, HOLD, '0, 0, 0, 0, '0);
        tick("abort.after");
        check("abort.nodone", 32'(done), 0);
        load(8'h01);
        drive(0, 1, SHL, '0, 0, 0, 1, CW'(2));
        tick("post.t");
        drive(0, 1, HOLD, '0, 0, 0, 0, '0);
        tick("post.1");
        tick("post.2");
        check("post.r", 32'(r), 32'h04);
        check("post.done", 32'(done), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)), W'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 5) == 0), CW'($urandom_range(0, (1 << CW) - 1)));
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
